// File: rtl/ipb_pkt_sequencer.sv
// ipb_pkt_sequencer: sequences IPbus packets through a ring of NSLOT buffer
// pages in the user_clk domain. It tracks host H2C writes, hands one page at
// a time to the IPbus transactor, requests a C2H read of each reply, and frees
// the page once the reply has been read.
// Optional feature: define IPB_SEQ_TIMEOUT_EN to enable the transactor
// response timeout (abandons the page after TIMEOUT_CYCLES in WAIT_DONE).
module ipb_pkt_sequencer #(
   parameter int NSLOT          = 4,
   parameter int SLOT_W         = $clog2(NSLOT),
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              user_clk,
   input  logic              user_rst,
   input  logic              h2c_dsc_done,
   output logic              h2c_ready,
   output logic [SLOT_W-1:0] h2c_slot,
   output logic              ipb_pkt_rdy,
   output logic [SLOT_W-1:0] ipb_slot,
   input  logic              ipb_pkt_done,
   output logic              c2h_req,
   output logic [SLOT_W-1:0] c2h_slot,
   input  logic              c2h_dsc_done,
   output logic [SLOT_W:0]   occupancy,
   output logic [15:0]       pkt_count,
   output logic              ovf_err,
   output logic              timeout_err,
   input  logic              err_clr
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_DONE = 2'd1,
      WAIT_C2H  = 2'd2
   } state_t;

   localparam logic [SLOT_W:0]   FULL     = (SLOT_W+1)'(NSLOT);
   localparam logic [SLOT_W:0]   OCC_ONE  = (SLOT_W+1)'(1);
   localparam logic [SLOT_W-1:0] SLOT_ONE = SLOT_W'(1);

   state_t            state, state_nxt;
   logic [SLOT_W-1:0] wp, rp;
   logic [SLOT_W:0]   occ_nxt;
   logic              full, accept, free, pkt_inc;
   logic              rdy_nxt, c2h_nxt;

`ifdef IPB_SEQ_TIMEOUT_EN
   localparam logic [23:0] TMO_LAST = 24'(TIMEOUT_CYCLES - 1);
   logic [23:0] timer;
   logic        tmo_fire;
`endif

   // full uses the pre-edge occupancy, so a same-edge free never rescues an overflow
   assign full     = (occupancy == FULL);
   assign accept   = h2c_dsc_done && !full;
   assign h2c_slot = wp;
   assign ipb_slot = rp;
   assign c2h_slot = rp;

   // state register
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) state <= IDLE;
      else          state <= state_nxt;
   end

   // next-state, handshake levels and page-free decisions
   always_comb begin
      state_nxt = state;
      rdy_nxt   = ipb_pkt_rdy;
      c2h_nxt   = c2h_req;
      free      = 1'b0;
      pkt_inc   = 1'b0;
`ifdef IPB_SEQ_TIMEOUT_EN
      tmo_fire  = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (occupancy != '0) begin
               state_nxt = WAIT_DONE;
               rdy_nxt   = 1'b1;
            end
         end
         WAIT_DONE: begin
            if (ipb_pkt_done) begin
               rdy_nxt   = 1'b0;
               c2h_nxt   = 1'b1;
               state_nxt = WAIT_C2H;
            end
`ifdef IPB_SEQ_TIMEOUT_EN
            else if (timer == TMO_LAST) begin
               rdy_nxt   = 1'b0;
               free      = 1'b1;
               tmo_fire  = 1'b1;
               state_nxt = IDLE;
            end
`endif
         end
         WAIT_C2H: begin
            if (c2h_dsc_done) begin
               c2h_nxt   = 1'b0;
               free      = 1'b1;
               pkt_inc   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            rdy_nxt   = 1'b0;
            c2h_nxt   = 1'b0;
         end
      endcase
   end

   // occupancy update: a same-edge accept and free cancel out
   always_comb begin
      occ_nxt = occupancy;
      case ({accept, free})
         2'b10:   occ_nxt = occupancy + OCC_ONE;
         2'b01:   occ_nxt = occupancy - OCC_ONE;
         default: occ_nxt = occupancy;
      endcase
   end

   // pointers, counters, registered outputs and overflow flag
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst) begin
         wp          <= '0;
         rp          <= '0;
         occupancy   <= '0;
         pkt_count   <= '0;
         h2c_ready   <= 1'b1;
         ovf_err     <= 1'b0;
         ipb_pkt_rdy <= 1'b0;
         c2h_req     <= 1'b0;
      end else begin
         if (accept)  wp <= wp + SLOT_ONE;
         if (free)    rp <= rp + SLOT_ONE;
         if (pkt_inc) pkt_count <= pkt_count + 16'd1;
         occupancy   <= occ_nxt;
         h2c_ready   <= (occ_nxt != FULL);
         ipb_pkt_rdy <= rdy_nxt;
         c2h_req     <= c2h_nxt;
         if (h2c_dsc_done && full) ovf_err <= 1'b1;
         else if (err_clr)         ovf_err <= 1'b0;
      end
   end

`ifdef IPB_SEQ_TIMEOUT_EN
   // response timer: zero outside WAIT_DONE, counts every cycle inside it
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst)                timer <= '0;
      else if (state == WAIT_DONE) timer <= timer + 24'd1;
      else                         timer <= '0;
   end

   // sticky timeout flag; a new timeout on the clear edge wins
   always_ff @(posedge user_clk or posedge user_rst) begin
      if (user_rst)      timeout_err <= 1'b0;
      else if (tmo_fire) timeout_err <= 1'b1;
      else if (err_clr)  timeout_err <= 1'b0;
   end
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_ipb_pkt_sequencer.sv
// Directed bench for ipb_pkt_sequencer: page slots are pushed to a scoreboard
// queue when the host write is accepted and popped when the page is served.
module tb_ipb_pkt_sequencer;
   localparam int NSLOT  = 4;
   localparam int SLOT_W = 2;
   localparam int TMO    = 16;

   logic              user_clk = 1'b0;
   logic              user_rst = 1'b1;
   logic              h2c_dsc_done = 1'b0;
   logic              ipb_pkt_done = 1'b0;
   logic              c2h_dsc_done = 1'b0;
   logic              err_clr = 1'b0;
   logic              h2c_ready, ipb_pkt_rdy, c2h_req, ovf_err, timeout_err;
   logic [SLOT_W-1:0] h2c_slot, ipb_slot, c2h_slot;
   logic [SLOT_W:0]   occupancy;
   logic [15:0]       pkt_count;

   int unsigned tests = 0;
   int unsigned fails = 0;
   int          wp_m, rp_m, occ_m, cnt_m;
   logic        ovf_m, tmo_m;
   int          slot_q[$];

   ipb_pkt_sequencer #(.NSLOT(NSLOT), .SLOT_W(SLOT_W), .TIMEOUT_CYCLES(TMO)) dut (
      .user_clk(user_clk), .user_rst(user_rst),
      .h2c_dsc_done(h2c_dsc_done), .h2c_ready(h2c_ready), .h2c_slot(h2c_slot),
      .ipb_pkt_rdy(ipb_pkt_rdy), .ipb_slot(ipb_slot), .ipb_pkt_done(ipb_pkt_done),
      .c2h_req(c2h_req), .c2h_slot(c2h_slot), .c2h_dsc_done(c2h_dsc_done),
      .occupancy(occupancy), .pkt_count(pkt_count),
      .ovf_err(ovf_err), .timeout_err(timeout_err), .err_clr(err_clr)
   );

   always #5 user_clk = ~user_clk;

   initial begin
      #300000;
      $display("FAIL watchdog: observed no finish, required finish before 300000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   task automatic model_reset();
      wp_m = 0; rp_m = 0; occ_m = 0; cnt_m = 0; ovf_m = 1'b0; tmo_m = 1'b0;
      slot_q.delete();
   endtask

   task automatic apply_reset();
      user_rst = 1'b1;
      tick();
      tick();
      user_rst = 1'b0;
      model_reset();
   endtask

   task automatic model_h2c();
      if (occ_m != NSLOT) begin
         slot_q.push_back(wp_m);
         wp_m = (wp_m + 1) % NSLOT;
         occ_m++;
      end else ovf_m = 1'b1;
   endtask

   task automatic model_free(input int pkt);
      rp_m  = (rp_m + 1) % NSLOT;
      occ_m--;
      cnt_m = (cnt_m + pkt) % 65536;
   endtask

   task automatic pulse_h2c();
      h2c_dsc_done = 1'b1;
      tick();
      h2c_dsc_done = 1'b0;
      model_h2c();
      check("h2c_slot", h2c_slot, wp_m);
      check("h2c_occ", occupancy, occ_m);
      check("h2c_ready", h2c_ready, occ_m != NSLOT);
      check("h2c_ovf", ovf_err, ovf_m);
   endtask

   task automatic pulse_clr();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      ovf_m = 1'b0; tmo_m = 1'b0;
      check("clr_ovf", ovf_err, ovf_m);
      check("clr_tmo", timeout_err, tmo_m);
   endtask

   task automatic wait_rdy(output int slot);
      int n = 0;
      while (!ipb_pkt_rdy && n < 20) begin
         tick();
         n++;
      end
      check("rdy_rise", ipb_pkt_rdy, 1'b1);
      slot = (slot_q.size() != 0) ? slot_q.pop_front() : 'x;
      check("ipb_slot", ipb_slot, slot);
   endtask

   task automatic serve_reply(input int slot);
      ipb_pkt_done = 1'b1;
      tick();
      ipb_pkt_done = 1'b0;
      check("done_rdy", ipb_pkt_rdy, 1'b0);
      check("done_c2h", c2h_req, 1'b1);
      check("c2h_slot", c2h_slot, slot);
   endtask

   task automatic finish_c2h();
      c2h_dsc_done = 1'b1;
      tick();
      c2h_dsc_done = 1'b0;
      model_free(1);
      check("fin_c2h", c2h_req, 1'b0);
      check("fin_occ", occupancy, occ_m);
      check("fin_cnt", pkt_count, cnt_m);
      check("fin_rdy_gap", ipb_pkt_rdy, 1'b0);
   endtask

   task automatic do_packet();
      int s;
      wait_rdy(s);
      tick();
      serve_reply(s);
      tick();
      finish_c2h();
   endtask

   initial begin
      int s;
      int n;
      model_reset();
      tick();
      check("rst_ready", h2c_ready, 1'b1);
      check("rst_occ", occupancy, 0);
      check("rst_rdy", ipb_pkt_rdy, 1'b0);
      check("rst_c2h", c2h_req, 1'b0);
      check("rst_cnt", pkt_count, 0);
      check("rst_ovf", ovf_err, 1'b0);
      check("rst_tmo", timeout_err, 1'b0);
      check("rst_slot", h2c_slot, 0);
      apply_reset();

      // stray handshakes while idle and empty are ignored
      ipb_pkt_done = 1'b1; c2h_dsc_done = 1'b1;
      tick();
      ipb_pkt_done = 1'b0; c2h_dsc_done = 1'b0;
      tick();
      check("stray_c2h", c2h_req, 1'b0);
      check("stray_rdy", ipb_pkt_rdy, 1'b0);
      check("stray_cnt", pkt_count, 0);

      // single packet with exact latencies
      repeat (8) tick();
      pulse_h2c();
      check("one_rdy_lat0", ipb_pkt_rdy, 1'b0);
      tick();
      check("one_rdy_lat1", ipb_pkt_rdy, 1'b1);
      wait_rdy(s);
      c2h_dsc_done = 1'b1;
      tick();
      c2h_dsc_done = 1'b0;
      check("ign_c2h_occ", occupancy, occ_m);
      check("ign_c2h_rdy", ipb_pkt_rdy, 1'b1);
      check("ign_c2h_cnt", pkt_count, cnt_m);
      repeat (5) tick();
      serve_reply(s);
      repeat (8) tick();
      finish_c2h();
      tick();
      check("one_idle_rdy", ipb_pkt_rdy, 1'b0);

      // fill, overflow, clear, set-beats-clear
      apply_reset();
      repeat (NSLOT) pulse_h2c();
      check("fill_occ", occupancy, NSLOT);
      check("fill_ready", h2c_ready, 1'b0);
      pulse_h2c();
      check("ovf_wp", h2c_slot, 0);
      pulse_clr();
      h2c_dsc_done = 1'b1; err_clr = 1'b1;
      tick();
      h2c_dsc_done = 1'b0; err_clr = 1'b0;
      model_h2c();
      check("set_wins_ovf", ovf_err, ovf_m);
      pulse_clr();

      // full with a same-edge free: still overflow, occupancy drops
      wait_rdy(s);
      serve_reply(s);
      c2h_dsc_done = 1'b1; h2c_dsc_done = 1'b1;
      tick();
      c2h_dsc_done = 1'b0; h2c_dsc_done = 1'b0;
      model_h2c();
      model_free(1);
      check("fullfree_occ", occupancy, occ_m);
      check("fullfree_ovf", ovf_err, ovf_m);
      check("fullfree_wp", h2c_slot, wp_m);
      check("fullfree_ready", h2c_ready, 1'b1);
      pulse_clr();
      while (occ_m != 0) do_packet();

      // simultaneous free and accept at occupancy 2
      apply_reset();
      pulse_h2c();
      pulse_h2c();
      wait_rdy(s);
      serve_reply(s);
      c2h_dsc_done = 1'b1; h2c_dsc_done = 1'b1;
      tick();
      c2h_dsc_done = 1'b0; h2c_dsc_done = 1'b0;
      model_h2c();
      model_free(1);
      check("sim_occ", occupancy, 2);
      check("sim_wp", h2c_slot, wp_m);
      check("sim_rp", c2h_slot, rp_m);
      check("sim_cnt", pkt_count, cnt_m);
      while (occ_m != 0) do_packet();

      // ten packets wrapping the ring from slot 0
      apply_reset();
      for (int i = 0; i < 10; i++) begin
         check("wrap_wp", h2c_slot, i % NSLOT);
         pulse_h2c();
         do_packet();
      end
      check("wrap_cnt", pkt_count, 10);

`ifdef IPB_SEQ_TIMEOUT_EN
      // timeout abandons the page without a reply
      pulse_h2c();
      wait_rdy(s);
      n = 0;
      while (ipb_pkt_rdy && n < 40) begin
         tick();
         n++;
      end
      model_free(0);
      tmo_m = 1'b1;
      check("tmo_cycles", n, TMO);
      check("tmo_err", timeout_err, tmo_m);
      check("tmo_c2h", c2h_req, 1'b0);
      check("tmo_occ", occupancy, occ_m);
      check("tmo_cnt", pkt_count, cnt_m);
      check("tmo_rp", ipb_slot, rp_m);
      pulse_clr();
      // reply on the timeout edge completes normally
      pulse_h2c();
      wait_rdy(s);
      repeat (TMO - 1) tick();
      serve_reply(s);
      check("tmo_edge_err", timeout_err, 1'b0);
      tick();
      finish_c2h();
`else
      // without the timeout feature the transactor wait is unbounded
      pulse_h2c();
      wait_rdy(s);
      n = 0;
      repeat (3 * TMO) begin
         tick();
         n++;
      end
      check("notmo_rdy", ipb_pkt_rdy, 1'b1);
      check("notmo_err", timeout_err, 1'b0);
      check("notmo_occ", occupancy, occ_m);
      serve_reply(s);
      tick();
      finish_c2h();
`endif

      // async reset in WAIT_C2H clears without a clock edge
      pulse_h2c();
      pulse_h2c();
      wait_rdy(s);
      serve_reply(s);
      #2;
      user_rst = 1'b1;
      #1;
      check("arst_c2h", c2h_req, 1'b0);
      check("arst_occ", occupancy, 0);
      check("arst_rdy", ipb_pkt_rdy, 1'b0);
      check("arst_ready", h2c_ready, 1'b1);
      check("arst_cnt", pkt_count, 0);
      tick();
      user_rst = 1'b0;
      model_reset();
      pulse_h2c();
      do_packet();
      check("arst_next_cnt", pkt_count, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/ipb_pkt_sequencer.md
# ipb_pkt_sequencer

Sequences IPbus packets through the PCIe transactor buffers in the user_clk (PCIe) domain. It manages a ring of NSLOT buffer pages. It tracks host H2C descriptor completions, presents one packet at a time to the IPbus transactor, and requests a C2H DMA for each reply. Each page is freed only after the reply has been read back. It sits between the XDMA descriptor status signals and the clock-domain-crossing / transactor buffer logic.

## Interface
Parameters:
- NSLOT, 4, number of buffer pages; power of 2, 2..16
- SLOT_W, $clog2(NSLOT), page index width
- TIMEOUT_CYCLES, 1000000, transactor response timeout in user_clk cycles, < 2^24

Ports:
- user_clk  in  1  sole clock
- user_rst  in  1  asynchronous, active-high reset
- h2c_dsc_done  in  1  one-cycle pulse: host finished writing page h2c_slot
- h2c_ready  out  1  at least one free page
- h2c_slot  out  SLOT_W  page the host must write next
- ipb_pkt_rdy  out  1  level: page ipb_slot holds a request for the transactor
- ipb_slot  out  SLOT_W  page being served
- ipb_pkt_done  in  1  one-cycle pulse, already in user_clk domain: reply written
- c2h_req  out  1  level: reply for c2h_slot ready for host DMA
- c2h_slot  out  SLOT_W  page whose reply is to be read
- c2h_dsc_done  in  1  one-cycle pulse: host finished reading reply
- occupancy  out  SLOT_W+1  pages written but not yet freed
- pkt_count  out  16  completed packets, wraps at 65535->0
- ovf_err  out  1  sticky: h2c_dsc_done received while full
- timeout_err  out  1  sticky: transactor timeout (see Configuration)
- err_clr  in  1  pulse: clears ovf_err and timeout_err

## Operation
- Reset (async assert, sync release): state IDLE. All pointers, occupancy, pkt_count and the timeout counter are 0. ipb_pkt_rdy, c2h_req, ovf_err and timeout_err are 0. h2c_ready=1.
- Write pointer wp, read pointer rp, both SLOT_W bits, wrap NSLOT-1 -> 0. h2c_slot=wp; ipb_slot=c2h_slot=rp.
- h2c_ready = (occupancy != NSLOT).
- h2c_dsc_done when not full: wp+1, occupancy+1.
- h2c_dsc_done when full: ignored, ovf_err set.
- FSM:
  - IDLE: if occupancy != 0, go to WAIT_DONE and set ipb_pkt_rdy=1, timer=0.
  - WAIT_DONE: on ipb_pkt_done, clear ipb_pkt_rdy, set c2h_req=1, go to WAIT_C2H. Otherwise timer+1 (Configuration).
  - WAIT_C2H: on c2h_dsc_done, clear c2h_req, rp+1, occupancy-1, pkt_count+1, go to IDLE.
- ipb_pkt_done outside WAIT_DONE is ignored. c2h_dsc_done outside WAIT_C2H is ignored.
- Same-edge free (rp advance) and h2c_dsc_done: occupancy is unchanged, both pointers advance.
- A same-edge h2c_dsc_done that arrives while full is still treated as overflow, even if a page frees on that edge; the full check uses the pre-edge occupancy.
- err_clr together with a new error event on the same edge: the set wins.

## Timing
- All outputs are registered.
- h2c_dsc_done sampled at edge N with the FSM idle and empty: occupancy=1 after N; ipb_pkt_rdy=1 after N+1.
- ipb_pkt_done sampled at edge M: ipb_pkt_rdy=0 and c2h_req=1 after M, with no overlap cycle.
- c2h_dsc_done sampled at edge K: c2h_req=0, rp and occupancy update after K. The next ipb_pkt_rdy rises after K+1 at the earliest.
- ipb_pkt_rdy is therefore low for at least one cycle between packets, which the downstream edge-detecting CDC requires.
- user_rst asserted mid-packet: all outputs clear immediately and every page is abandoned.

## Configuration
- IPB_SEQ_TIMEOUT_EN defined:
  - In WAIT_DONE the 24-bit timer counts each cycle.
  - When timer==TIMEOUT_CYCLES-1 and ipb_pkt_done is absent at that edge: clear ipb_pkt_rdy, set timeout_err, rp+1, occupancy-1, go to IDLE. pkt_count is unchanged and no C2H request is made.
  - ipb_pkt_done on the timeout edge wins; normal completion applies.
- IPB_SEQ_TIMEOUT_EN undefined: no timer logic, timeout_err is tied 0, WAIT_DONE waits indefinitely.

## Test plan
- Reset then one packet: h2c_dsc_done pulse at cycle 10 -> ipb_pkt_rdy=1 from cycle 12, ipb_slot=0. ipb_pkt_done at 20 -> c2h_req=1 at 21, c2h_slot=0. c2h_dsc_done at 30 -> occupancy=0, pkt_count=1.
- Fill: 4 h2c_dsc_done pulses with NSLOT=4 and the transactor stalled -> occupancy=4, h2c_ready=0. A 5th pulse -> ovf_err=1, wp stays 0. err_clr -> ovf_err=0.
- Wrap: 10 full packet cycles -> ipb_slot sequence 0,1,2,3,0,1,2,3,0,1; pkt_count=10.
- Simultaneous: c2h_dsc_done and h2c_dsc_done on the same edge at occupancy=2 -> occupancy stays 2, rp and wp both advance.
- Timeout (macro on, TIMEOUT_CYCLES=16): no ipb_pkt_done -> ipb_pkt_rdy drops 16 cycles after it rose, timeout_err=1, occupancy-1, pkt_count unchanged. Repeat with ipb_pkt_done on the 16th cycle -> normal c2h_req, timeout_err=0.
- Async reset asserted in WAIT_C2H -> c2h_req=0 and occupancy=0 without waiting for a clock edge; the next packet uses slot 0.
